// File: rtl/mul_issue_queue.sv
// Operand FIFO + issue/collect sequencer for the 32-bit sequential multiplier; `MULT_ISSUE_TIMEOUT_EN adds a WAIT watchdog.
// Latency: push at edge P -> mul_start after P+1, out_valid after P+37 (35-cycle multiplier).
// Backpressure: in_ready drops when the FIFO is full; a stalled result parks in HOLD, blocking further issue.

module mul_iq_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module mul_issue_queue #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_product,
    output logic                   out_err,
    output logic                   mul_start,
    output logic [31:0]            mul_multiplicand,
    output logic [31:0]            mul_multiplier,
    input  logic [31:0]            mul_product,
    input  logic                   mul_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } opnd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t      state, state_nxt;
    opnd_t       head;
    logic        push, pop, slot_free, load, load_err;
    logic [31:0] load_prod;
    logic        tmo_hit, hold_err;

    assign in_ready  = !rst && (fifo_count != FULL);
    assign push      = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != S_IDLE);

    mul_iq_fifo #(.W($bits(opnd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({in_a, in_b}),
        .pop      (pop),
        .pop_dat  (head),
        .count    (fifo_count)
    );

`ifdef MULT_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wait_cnt <= '0;
        else if (state == S_ISSUE) wait_cnt <= '0;
        else if (state == S_WAIT)  wait_cnt <= wait_cnt + TW'(1);
    end

    assign tmo_hit = (state == S_WAIT) && !mul_done && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        load_prod = mul_product;
        load_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            // The multiplier drops a stale done only on the edge that samples start.
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (mul_done || tmo_hit) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_prod = tmo_hit ? 32'h0 : mul_product;
                        load_err  = tmo_hit;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_prod = hold_err ? 32'h0 : mul_product;
                    load_err  = hold_err;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_start        <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
            out_err          <= 1'b0;
            hold_err         <= 1'b0;
        end else begin
            mul_start <= pop;
            if (pop) begin
                mul_multiplicand <= head.a;
                mul_multiplier   <= head.b;
            end
            if (state == S_WAIT) hold_err <= tmo_hit;
            if (load) begin
                out_valid   <= 1'b1;
                out_product <= load_prod;
                out_err     <= load_err;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end
endmodule
